// File: rtl/therm_step_seq.sv
// rtl/therm_step_seq.sv - steps a 0..4 level pointer and presents legal thermometer codes over valid/ready
// Optional abort port pair enabled by defining THERM_SEQ_ABORT_EN.
module therm_step_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               code_ready,
`ifdef THERM_SEQ_ABORT_EN
  input  logic               abort,
  output logic               abort_ack,
`endif
  output logic [3:0]         code_out,
  output logic               code_valid,
  output logic [2:0]         level,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, PRESENT, DWELL} state_t;

  state_t             state;
  logic               dir_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
  logic [2:0]         target;
  logic [2:0]         step_level;
  logic               abort_req;

  function automatic logic [3:0] therm(input logic [2:0] l);
    case (l)
      3'd0:    therm = 4'b0000;
      3'd1:    therm = 4'b0001;
      3'd2:    therm = 4'b0011;
      3'd3:    therm = 4'b0111;
      default: therm = 4'b1111;
    endcase
  endfunction

  assign target     = dir_q ? 3'd4 : 3'd0;
  // DWELL is only entered when level differs from target, so the step stays inside 0..4.
  assign step_level = dir_q ? level + 3'd1 : level - 3'd1;

`ifdef THERM_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      dwell_q    <= '0;
      cnt        <= '0;
      level      <= 3'd0;
      code_out   <= 4'b0000;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef THERM_SEQ_ABORT_EN
      abort_ack  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef THERM_SEQ_ABORT_EN
      abort_ack <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            dir_q      <= dir;
            dwell_q    <= dwell;
            state      <= PRESENT;
            code_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        PRESENT: begin
          // Abort wins over a coincident handshake: the code counts as taken but no done.
          if (abort_req) begin
            state      <= IDLE;
            code_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef THERM_SEQ_ABORT_EN
            abort_ack  <= 1'b1;
`endif
          end else if (code_ready) begin
            code_valid <= 1'b0;
            if (level == target) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DWELL;
              cnt   <= dwell_q;
            end
          end
        end
        DWELL: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef THERM_SEQ_ABORT_EN
            abort_ack <= 1'b1;
`endif
          end else if (cnt == '0) begin
            level      <= step_level;
            code_out   <= therm(step_level);
            state      <= PRESENT;
            code_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_therm_step_seq.sv
// tb/tb_therm_step_seq.sv - vector table, directed ramps and random run against a queue-based model
module tb_therm_step_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic       code_ready = 1'b0;
  logic [3:0] code_out;
  logic       code_valid;
  logic [2:0] level;
  logic       busy;
  logic       done;
`ifdef THERM_SEQ_ABORT_EN
  logic       abort = 1'b0;
  logic       abort_ack;
`endif

  int checks = 0;
  int errors = 0;

  therm_step_seq #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .dwell(dwell),
    .code_ready(code_ready),
`ifdef THERM_SEQ_ABORT_EN
    .abort(abort), .abort_ack(abort_ack),
`endif
    .code_out(code_out), .code_valid(code_valid), .level(level),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] therm_of(input int l);
    logic [4:0] t;
    t = (5'd1 << l) - 5'd1;
    return t[3:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a queue of levels still to be handshaken for the current ramp.
  int         q[$];
  int         cyc = 0;
  int         mdl_level = 0;
  int         mdl_dwell = 0;
  int         exp_rise = -1;
  int         prev_level = 0;
  logic       mdl_busy = 0, nxt_busy = 0;
  logic       exp_done = 0, nxt_done = 0;
  logic       exp_ack = 0, nxt_ack = 0;
  logic       prev_valid = 0, prev_rel = 0;
  logic [3:0] prev_code = 0;

  always @(negedge clk) begin : mon
    int  dl;
    int  l;
    logic hs, rel;
    cyc++;
    if (!rst_n) begin
      q.delete();
      mdl_level = 0; mdl_busy = 0; nxt_busy = 0; nxt_done = 0; nxt_ack = 0;
      exp_rise = -1; prev_valid = 0; prev_rel = 0; prev_level = 0; prev_code = 0;
    end else begin
      mdl_busy = nxt_busy; exp_done = nxt_done; exp_ack = nxt_ack;
      nxt_done = 0; nxt_ack = 0;
      if (code_valid && !prev_valid) begin
        chk("rise_time", cyc, exp_rise);
        exp_rise = -1;
        chk("rise_expected", q.size() > 0, 1);
        if (q.size() > 0) mdl_level = q[0];
      end
      if (exp_rise >= 0 && cyc > exp_rise) begin
        chk("rise_missing", code_valid, 1);
        exp_rise = -1;
      end
      if (prev_valid && !prev_rel) chk("hold", {code_valid, code_out}, {1'b1, prev_code});
      chk("busy", busy, mdl_busy);
      chk("done", done, exp_done);
      chk("level", level, mdl_level);
      chk("code_of_level", code_out, therm_of(level));
      dl = int'(level) - prev_level;
      chk("step_size", (dl >= -1 && dl <= 1), 1);
      chk("done_with_valid", done & code_valid, 0);
      if (code_valid) chk("legal", code_out inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hf}, 1);
`ifdef THERM_SEQ_ABORT_EN
      chk("abort_ack", abort_ack, exp_ack);
`endif
      hs  = code_valid && code_ready;
      rel = hs;
      if (hs) begin
        chk("hs_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("hs_code", code_out, therm_of(q[0]));
          void'(q.pop_front());
          if (q.size() == 0) begin
            nxt_done = 1;
            nxt_busy = 0;
          end else begin
            exp_rise = cyc + mdl_dwell + 2;
          end
        end
      end
`ifdef THERM_SEQ_ABORT_EN
      if (abort && mdl_busy) begin
        q.delete();
        nxt_done = 0; nxt_busy = 0; nxt_ack = 1; exp_rise = -1; rel = 1;
      end
`endif
      if (!mdl_busy && start) begin
        l = mdl_level;
        q.push_back(l);
        while (l != (dir ? 4 : 0)) begin
          l = dir ? l + 1 : l - 1;
          q.push_back(l);
        end
        mdl_dwell = int'(dwell);
        nxt_busy  = 1;
        exp_rise  = cyc + 1;
      end
      prev_valid = code_valid; prev_rel = rel; prev_code = code_out; prev_level = int'(level);
    end
  end

  typedef struct {
    logic       st;
    logic       dr;
    logic [7:0] dw;
    logic       rdy;
    logic       v;
    logic [3:0] code;
    logic [2:0] lvl;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t vecs[18];

  task automatic run_ramp(input logic d, input logic [7:0] dw, input int hold,
                          input int from_lvl, input logic pester);
    int exp_l[$];
    int l, n, waitc, dones, last_hs, c;
    l = from_lvl; n = 0; waitc = 0; dones = 0; last_hs = -1; c = 0;
    exp_l.push_back(l);
    while (l != (d ? 4 : 0)) begin
      l = d ? l + 1 : l - 1;
      exp_l.push_back(l);
    end
    start = 1; dir = d; dwell = dw; code_ready = 0;
    tick;
    start = 0;
    for (int k = 0; k < 400 && dones == 0; k++) begin
      c++;
      if (done) begin
        dones++;
        chk("ramp_done_time", c, last_hs + 1);
        chk("ramp_count", n, exp_l.size());
      end
      code_ready = 0;
      start = pester & busy;
      if (code_valid) begin
        if (waitc < hold) waitc++;
        else begin
          code_ready = 1;
          if (n < exp_l.size()) chk("ramp_code", code_out, therm_of(exp_l[n]));
          if (hold == 0 && last_hs >= 0) chk("ramp_gap", c - last_hs, int'(dw) + 2);
          last_hs = c; n++; waitc = 0;
        end
      end
      tick;
    end
    start = 0; code_ready = 0;
    chk("ramp_finished", dones, 1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("ramp_quiet", {done, code_valid, busy}, 3'b000);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b0001, 3'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 4'b0011, 3'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0111, 3'd3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b0111, 3'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b1111, 3'd4, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b1111, 3'd4, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0111, 3'd3, 1'b1, 1'b0};

    tick; tick;
    chk("reset_state", {code_valid, code_out, level, busy, done}, 10'b0);
    rst_n = 1;
    tick;

    foreach (vecs[i]) begin
      start = vecs[i].st; dir = vecs[i].dr; dwell = vecs[i].dw; code_ready = vecs[i].rdy;
      tick;
      chk($sformatf("vec%0d_valid", i), code_valid, vecs[i].v);
      chk($sformatf("vec%0d_code", i), code_out, vecs[i].code);
      chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d_done", i), done, vecs[i].dn);
    end
    start = 0; code_ready = 1;
    for (int k = 0; k < 60 && !done; k++) tick;
    chk("drain_done", done, 1);
    chk("drain_level", level, 0);
    code_ready = 0;
    tick;

    run_ramp(1'b1, 8'd3, 0, 0, 1'b0);
    chk("up_level", level, 4);
    run_ramp(1'b1, 8'd2, 1, 4, 1'b1);
    run_ramp(1'b0, 8'd0, 4, 4, 1'b0);
    chk("down_level", level, 0);

    start = 1; dir = 1; dwell = 0;
    tick;
    start = 0; code_ready = 1;
    for (int k = 0; k < 40 && !(level == 3'd2 && code_valid); k++) tick;
    chk("reach_level2", {level, code_valid}, {3'd2, 1'b1});
    rst_n = 0;
    #1;
    chk("async_reset", {code_out, level, code_valid, busy, done}, 10'b0);
    tick;
    rst_n = 1; code_ready = 0;
    tick;
    chk("post_reset", {level, busy}, 4'b0);

`ifdef THERM_SEQ_ABORT_EN
    start = 1; dir = 1; dwell = 3;
    tick;
    start = 0;
    for (int k = 0; k < 60 && !(level == 3'd2 && !code_valid && busy); k++) begin
      code_ready = code_valid;
      tick;
    end
    chk("abort_setup", {level, code_valid, busy}, {3'd2, 1'b0, 1'b1});
    code_ready = 0; abort = 1;
    tick;
    abort = 0;
    chk("abort_pulse", {abort_ack, busy, done, code_valid, level}, {4'b1000, 3'd2});
    tick;
    chk("abort_after", {abort_ack, done, level}, {2'b00, 3'd2});
    run_ramp(1'b1, 8'd0, 0, 2, 1'b0);
`endif

    for (int i = 0; i < 10000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      dir        = 1'($urandom_range(0, 1));
      dwell      = 8'($urandom_range(0, 3));
      code_ready = 1'($urandom_range(0, 1));
`ifdef THERM_SEQ_ABORT_EN
      abort      = ($urandom_range(0, 49) == 0);
`endif
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/therm_step_seq.md
Name: therm_step_seq

Overview:
- Upstream driver for the 4-bit thermometer-code lookup stage that maps {0000,0001,0011,0111,1111} to 32-bit constants.
- Walks a level pointer (0..4) up or down one step at a time and presents each legal thermometer code over a valid/ready handshake.
- Holds each level for a programmable dwell time before taking the next step.
- Guarantees the downstream lookup never sees an illegal (default-branch) code.

Parameters:
- DWELL_W, 8: width of the dwell-count input and internal dwell counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a ramp; sampled only in IDLE.
- dir  in  1  ramp direction, sampled with start: 1 = up (target level 4), 0 = down (target level 0).
- dwell  in  DWELL_W  cycles to wait after each accepted code, sampled with start.
- code_out  out  4  thermometer code for the current level.
- code_valid  out  1  code_out is presented to the downstream stage.
- code_ready  in  1  downstream accepts code_out.
- level  out  3  current level pointer, 0..4.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the target-level code has been accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, level=0, code_out=4'b0000, code_valid=0, busy=0, done=0, dwell counter=0.
  - Applies immediately, including mid-ramp; any in-flight transaction is dropped.
- Code map (registered, always derived from level):
  - 0->0000, 1->0001, 2->0011, 3->0111, 4->1111.
  - level never leaves 0..4.
- States:
  - IDLE:
    - code_valid=0.
    - start=1: latch dir and dwell, go to PRESENT next cycle; busy rises in the same cycle as PRESENT is entered.
    - start while busy is ignored.
  - PRESENT:
    - code_valid=1; code_out and level held stable until code_valid & code_ready.
    - On handshake, if level==target: pulse done next cycle and go to IDLE.
    - On handshake otherwise: go to DWELL with counter loaded from latched dwell.
    - code_valid drops the cycle after the handshake.
  - DWELL:
    - code_valid=0; counter decrements each cycle.
    - When counter is 0, step level toward target (+1 up, -1 down) and go to PRESENT.
    - Latched dwell=0 gives exactly one DWELL cycle, so consecutive presents are separated by 1 idle cycle minimum.
- Ramp content:
  - The first presented code is the current level's code (no step first).
  - The last presented code is the target code.
  - Already at target: exactly one transaction, then done.
- Timing:
  - With code_ready tied high and dwell=D, each non-final step takes 2+D cycles from handshake to next handshake.
  - A full 0->4 ramp performs 5 handshakes.
- code_ready while code_valid=0 is ignored.
- done is high only in IDLE, one cycle, and never coincides with code_valid.
- level persists across ramps; successive start commands continue from it.

Optional Feature:
- Macro THERM_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output abort_ack (1 bit, reset 0).
  - abort=1 in PRESENT or DWELL: go to IDLE next cycle, code_valid=0, abort_ack pulses one cycle, no done, level keeps its current value.
  - An abort coinciding with a handshake in PRESENT takes priority: the handshake counts as accepted, but no done is issued.
  - abort in IDLE has no effect.
- Undefined: neither port exists; a ramp always runs to target.

Test Plan:
- Reset mid-ramp: assert rst_n=0 while level=2 and code_valid=1 -> same-cycle code_out=0000, level=0, code_valid=0, busy=0.
- Up-ramp, ready high: start, dir=1, dwell=3, from level 0 -> codes 0000,0001,0011,0111,1111 accepted 5 cycles apart; done one cycle after the 1111 handshake; level=4.
- Down-ramp with backpressure: from level 4, dir=0, dwell=0, ready low 4 cycles on each present -> code_out stable while waiting; sequence 1111,0111,0011,0001,0000; done once.
- Already at target: level=4, start dir=1 -> exactly one 1111 handshake then done; start asserted during busy is ignored (no second ramp).
- Legality: random start/dir/dwell/ready for 10k cycles -> code_out always in the five legal codes whenever code_valid=1; level changes by at most 1 per step.
- THERM_SEQ_ABORT_EN: abort in DWELL at level 2 of an up-ramp -> abort_ack pulse, IDLE, level=2, no done; next start dir=1 presents 0011 first.
